trigger_rs: RTL and testbench

Clocked RS (set/reset) trigger: a synchronous storage element that sets, clears or holds its state on each rising clock edge according to the `s` and `r` request inputs. It is a generic state-flag primitive for control logic, such as latching an event until it is explicitly cleared. An optional vector width replicates independent RS cells sharing one clock and reset. The `s = r = 1` case is resolved by a compile-time policy, never left undefined.

---
 rtl/trigger_rs_pkg.sv | 34 +++
 rtl/trigger_rs_cell.sv | 36 +++
 rtl/trigger_rs.sv | 51 +++++
 tb/tb_trigger_rs.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/trigger_rs_pkg.sv
// rtl/trigger_rs_pkg.sv - shared types and next-state function for the RS trigger
package trigger_rs_pkg;

    // How a cell resolves a simultaneous set and reset request
    typedef enum logic [1:0] {
        RS_RESET_DOM = 2'd0,
        RS_SET_DOM   = 2'd1,
        RS_HOLD      = 2'd2,
        RS_TOGGLE    = 2'd3
    } rs_policy_e;

    // Next state of one RS cell given current state, requests and conflict policy
    function automatic logic rs_next(input logic q, input logic s, input logic r,
                                     input rs_policy_e policy);
        logic w_next;
        w_next = q;
        case ({s, r})
            2'b00: w_next = q;
            2'b10: w_next = 1'b1;
            2'b01: w_next = 1'b0;
            default: begin
                case (policy)
                    RS_RESET_DOM: w_next = 1'b0;
                    RS_SET_DOM:   w_next = 1'b1;
                    RS_HOLD:      w_next = q;
                    RS_TOGGLE:    w_next = ~q;
                    default:      w_next = 1'b0;
                endcase
            end
        endcase
        return w_next;
    endfunction

endpackage

// File: rtl/trigger_rs_cell.sv
// rtl/trigger_rs_cell.sv - single-bit clocked RS storage cell
module trigger_rs_cell
    import trigger_rs_pkg::*;
#(
    parameter rs_policy_e BOTH_POLICY = RS_RESET_DOM,
    parameter logic       RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_n,
    output logic conflict
);

    logic r_q;
    logic r_conflict;

    // State and conflict flag update; reset forces the load value at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q        <= RST_VAL;
            r_conflict <= 1'b0;
        end else begin
            r_q        <= rs_next(r_q, s, r, BOTH_POLICY);
            r_conflict <= s & r;
        end
    end

    // Complement comes straight off the state flop, no second register
    assign q        = r_q;
    assign q_n      = ~r_q;
    assign conflict = r_conflict;

endmodule

// File: rtl/trigger_rs.sv
// rtl/trigger_rs.sv - vector of independent clocked RS triggers
module trigger_rs
    import trigger_rs_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter rs_policy_e       BOTH_POLICY = RS_RESET_DOM,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] conflict
);

    // Reject nonsensical configurations before anything is built
    if (WIDTH < 1) begin : g_bad_width
        $error("trigger_rs: WIDTH must be at least 1");
    end
    if ((BOTH_POLICY != RS_RESET_DOM) && (BOTH_POLICY != RS_SET_DOM) &&
        (BOTH_POLICY != RS_HOLD) && (BOTH_POLICY != RS_TOGGLE)) begin : g_bad_policy
        $error("trigger_rs: BOTH_POLICY is not a defined rs_policy_e value");
    end

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_n;
    logic [WIDTH-1:0] w_conflict;

    // One independent cell per bit, all sharing clock and reset
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        trigger_rs_cell #(
            .BOTH_POLICY (BOTH_POLICY),
            .RST_VAL     (RST_VAL[g])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .s        (s[g]),
            .r        (r[g]),
            .q        (w_q[g]),
            .q_n      (w_q_n[g]),
            .conflict (w_conflict[g])
        );
    end

    assign q        = w_q;
    assign q_n      = w_q_n;
    assign conflict = w_conflict;

endmodule

// File: tb/tb_trigger_rs.sv
// tb/tb_trigger_rs.sv - self-checking bench for trigger_rs across all conflict policies
module tb_trigger_rs;
    import trigger_rs_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;

    logic [3:0] q_o  [4];
    logic [3:0] qn_o [4];
    logic [3:0] c_o  [4];
    logic       dq, dqn, dc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_q [4];
    logic [3:0] m_c;
    logic [3:0] rstv [4];

    always #5 clk = ~clk;

    trigger_rs #(.WIDTH(4), .BOTH_POLICY(RS_RESET_DOM), .RST_VAL(4'b0000)) u_rd (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q_o[0]), .q_n(qn_o[0]), .conflict(c_o[0]));
    trigger_rs #(.WIDTH(4), .BOTH_POLICY(RS_SET_DOM), .RST_VAL(4'b0000)) u_sd (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q_o[1]), .q_n(qn_o[1]), .conflict(c_o[1]));
    trigger_rs #(.WIDTH(4), .BOTH_POLICY(RS_HOLD), .RST_VAL(4'b0000)) u_hd (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q_o[2]), .q_n(qn_o[2]), .conflict(c_o[2]));
    trigger_rs #(.WIDTH(4), .BOTH_POLICY(RS_TOGGLE), .RST_VAL(4'b1010)) u_tg (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q_o[3]), .q_n(qn_o[3]), .conflict(c_o[3]));
    trigger_rs u_def (
        .clk(clk), .rst(rst), .s(s[0]), .r(r[0]), .q(dq), .q_n(dqn), .conflict(dc));

    // Reference: set wins alone, reset wins alone, idle holds, both -> policy value
    function automatic logic [3:0] model_next(int pol, logic [3:0] q, logic [3:0] si, logic [3:0] ri);
        logic [3:0] both_val;
        case (pol)
            0:       both_val = 4'b0000;
            1:       both_val = 4'b1111;
            2:       both_val = q;
            default: both_val = ~q;
        endcase
        return (q & ~si & ~ri) | (si & ~ri) | (si & ri & both_val);
    endfunction

    task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check_vec($sformatf("%s q[%0d]", tag, i), q_o[i], m_q[i]);
            check_vec($sformatf("%s q_n[%0d]", tag, i), qn_o[i], ~m_q[i]);
            check_vec($sformatf("%s conflict[%0d]", tag, i), c_o[i], m_c);
        end
        check_vec({tag, " def q"}, {3'b000, dq}, {3'b000, m_q[0][0]});
        check_vec({tag, " def q_n"}, {3'b000, dqn}, {3'b000, ~m_q[0][0]});
        check_vec({tag, " def conflict"}, {3'b000, dc}, {3'b000, m_c[0]});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_q[i] = rstv[i];
        m_c = 4'b0000;
    endtask

    task automatic step(input logic [3:0] si, input logic [3:0] ri, input string tag);
        logic [3:0] nxt [4];
        @(negedge clk);
        s = si;
        r = ri;
        for (int i = 0; i < 4; i++) nxt[i] = model_next(i, m_q[i], si, ri);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) m_q[i] = nxt[i];
        m_c = si & ri;
        check_all(tag);
    endtask

    // Hold reset with set requested and the clock running, then release cleanly
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst-assert");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s = 4'b1111;
            r = 4'b0000;
            @(posedge clk);
            #1;
            check_all("rst-held");
        end
        @(negedge clk);
        s = 4'b0000;
        r = 4'b0000;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] exp_q;
        logic [3:0] exp_c;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rstv[0] = 4'b0000;
        rstv[1] = 4'b0000;
        rstv[2] = 4'b0000;
        rstv[3] = 4'b1010;
        rst = 1'b0;
        s = 4'b0000;
        r = 4'b0000;
        model_reset();

        // Reset-dominant expectations, written out by hand
        tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        tbl[1] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[2] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        tbl[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[7] = '{4'b0011, 4'b0110, 4'b0001, 4'b0010};

        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s, tbl[i].r, $sformatf("tbl%0d", i));
            check_vec($sformatf("tbl%0d rd q", i), q_o[0], tbl[i].exp_q);
            check_vec($sformatf("tbl%0d rd conflict", i), c_o[0], tbl[i].exp_c);
        end

        // Mid-run reset drops q without any clock edge
        step(4'b1111, 4'b0000, "pre-midrst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        check_vec("midrst rd q immediate", q_o[0], 4'b0000);
        check_vec("midrst tg q immediate", q_o[3], 4'b1010);
        @(negedge clk);
        s = 4'b0000;
        r = 4'b0000;
        rst = 1'b1;

        // Policy sweep: two conflict edges from reset state, then from all ones
        apply_reset();
        step(4'b1111, 4'b1111, "sweep0a");
        check_vec("sweep0a rd", q_o[0], 4'b0000);
        check_vec("sweep0a sd", q_o[1], 4'b1111);
        check_vec("sweep0a hd", q_o[2], 4'b0000);
        check_vec("sweep0a tg", q_o[3], 4'b0101);
        check_vec("sweep0a conflict", c_o[3], 4'b1111);
        step(4'b1111, 4'b1111, "sweep0b");
        check_vec("sweep0b rd", q_o[0], 4'b0000);
        check_vec("sweep0b sd", q_o[1], 4'b1111);
        check_vec("sweep0b hd", q_o[2], 4'b0000);
        check_vec("sweep0b tg", q_o[3], 4'b1010);
        step(4'b1111, 4'b0000, "sweep-set");
        step(4'b1111, 4'b1111, "sweep1a");
        check_vec("sweep1a rd", q_o[0], 4'b0000);
        check_vec("sweep1a sd", q_o[1], 4'b1111);
        check_vec("sweep1a hd", q_o[2], 4'b1111);
        check_vec("sweep1a tg", q_o[3], 4'b0000);
        step(4'b1111, 4'b1111, "sweep1b");
        check_vec("sweep1b rd", q_o[0], 4'b0000);
        check_vec("sweep1b sd", q_o[1], 4'b1111);
        check_vec("sweep1b hd", q_o[2], 4'b1111);
        check_vec("sweep1b tg", q_o[3], 4'b1111);
        step(4'b0000, 4'b0000, "sweep-idle");
        check_vec("sweep-idle conflict", c_o[0], 4'b0000);

        // Set pulse lying entirely between two rising edges is ignored
        apply_reset();
        @(posedge clk);
        #2;
        s = 4'b1111;
        #2;
        s = 4'b0000;
        step(4'b0000, 4'b0000, "glitch");
        check_vec("glitch rd q", q_o[0], 4'b0000);

        // Random traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            step(4'($urandom), 4'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
